// File: rtl/mem_arb_pkg.sv
// Shared encodings for mem_arbiter: access sizes, FSM states, byte-lane masks and the latched request.
package mem_arb_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [3:0] LANE_B = 4'b0001;
    localparam logic [3:0] LANE_H = 4'b0011;
    localparam logic [3:0] LANE_W = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MRG,
        WR,
        DONE
    } state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic [1:0]  boff;
        logic [31:0] wdata;
    } req_t;

    // Size 11 has no legal alignment, so it is reported the same way as a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] boff);
        logic bad;
        bad = 1'b1;
        if (size == SZ_B)      bad = 1'b0;
        else if (size == SZ_H) bad = boff[0];
        else if (size == SZ_W) bad = (boff != 2'b00);
        return bad;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Two-port request/response bundle between requesters (master) and mem_arbiter (slave).
interface mem_arbiter_if;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [1:0][1:0]  req_size;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_err;
    logic [31:0]      resp_rdata;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );

endinterface

// File: rtl/mem_arb_lane_merge.sv
// Combinational little-endian lane merge: drops byte/half store data into its lanes of old_word.
// Also yields the lane mask; size 11 is treated as a full word (never reaches here in practice).
module mem_arb_lane_merge
    import mem_arb_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  addr,
    output logic [31:0] merged,
    output logic [3:0]  mask
);

    logic [31:0] repl;

    always_comb begin
        repl   = wdata;
        mask   = LANE_W;
        merged = old_word;
        if (size == SZ_B) begin
            repl = {4{wdata[7:0]}};
            mask = LANE_B << addr;
        end else if (size == SZ_H) begin
            repl = {2{wdata[15:0]}};
            mask = LANE_H << {addr[1], 1'b0};
        end
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) merged[8*i +: 8] = repl[8*i +: 8];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter for a single-port sync-read memory; load/SW 2 cycles, RMW 4, misaligned 1.
// One access in flight (req_ready only in IDLE); MEM_ARB_BYTEMASK_EN adds mem_be and skips RMW.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_if.slave      bus,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef MEM_ARB_BYTEMASK_EN
    ,
    output logic [3:0]        mem_be
`endif
);

    state_t      state;
    logic        ptr;
    logic        gnt;
    logic        rd_resp;
    req_t        lat;

    logic        any_vld;
    logic        sel;
    logic        accept;
    logic [31:0] in_addr;
    req_t        in_req;

    logic [31:0] mg_old;
    logic [31:0] mg_wdata;
    logic [31:0] mg_merged;
    logic [1:0]  mg_size;
    logic [1:0]  mg_boff;
    logic [3:0]  mg_mask;
    logic        unused_bits;

    assign any_vld = |bus.req_valid;
    assign sel     = (&bus.req_valid) ? ptr : bus.req_valid[1];
    assign accept  = !rst && (state == IDLE) && any_vld;
    assign in_addr = bus.req_addr[sel];
    assign in_req  = '{we: bus.req_we[sel], size: bus.req_size[sel],
                       boff: in_addr[1:0], wdata: bus.req_wdata[sel]};

    always_comb begin
        bus.req_ready      = 2'b00;
        bus.req_ready[sel] = accept;
    end

    // The memory's own output register holds the read word during DONE, so it is gated straight out.
    assign bus.resp_rdata = rd_resp ? mem_rdata : 32'h0;

`ifdef MEM_ARB_BYTEMASK_EN
    assign mg_old      = 32'h0;
    assign mg_wdata    = in_req.wdata;
    assign mg_size     = in_req.size;
    assign mg_boff     = in_req.boff;
    assign unused_bits = ^{bus.req_addr[0][31:ADDR_W+2], bus.req_addr[1][31:ADDR_W+2],
                           lat.size, lat.boff, lat.wdata};
`else
    assign mg_old      = mem_rdata;
    assign mg_wdata    = lat.wdata;
    assign mg_size     = lat.size;
    assign mg_boff     = lat.boff;
    assign unused_bits = ^{bus.req_addr[0][31:ADDR_W+2], bus.req_addr[1][31:ADDR_W+2], mg_mask};
`endif

    mem_arb_lane_merge u_merge (
        .old_word (mg_old),
        .wdata    (mg_wdata),
        .size     (mg_size),
        .addr     (mg_boff),
        .merged   (mg_merged),
        .mask     (mg_mask)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= 1'b0;
            gnt            <= 1'b0;
            rd_resp        <= 1'b0;
            lat            <= '0;
            mem_en         <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= 32'h0;
            bus.resp_valid <= 2'b00;
            bus.resp_err   <= 2'b00;
`ifdef MEM_ARB_BYTEMASK_EN
            mem_be         <= 4'h0;
`endif
        end else begin
            bus.resp_valid <= 2'b00;
            bus.resp_err   <= 2'b00;
            rd_resp        <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_vld) begin
                        gnt      <= sel;
                        ptr      <= ~sel;
                        lat      <= in_req;
                        mem_addr <= in_addr[ADDR_W+1:2];
                        if (is_misaligned(in_req.size, in_req.boff)) begin
                            state               <= DONE;
                            bus.resp_valid[sel] <= 1'b1;
                            bus.resp_err[sel]   <= 1'b1;
`ifdef MEM_ARB_BYTEMASK_EN
                        end else if (in_req.we) begin
                            state     <= WR;
                            mem_en    <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_wdata <= mg_merged;
                            mem_be    <= mg_mask;
`else
                        end else if (in_req.we && in_req.size == SZ_W) begin
                            state     <= WR;
                            mem_en    <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_wdata <= in_req.wdata;
`endif
                        end else begin
                            state  <= RD;
                            mem_en <= 1'b1;
                            mem_we <= 1'b0;
                        end
                    end
                end
                RD: begin
                    mem_en <= 1'b0;
                    if (lat.we) begin
                        state <= MRG;
                    end else begin
                        state               <= DONE;
                        bus.resp_valid[gnt] <= 1'b1;
                        rd_resp             <= 1'b1;
                    end
                end
                MRG: begin
                    state     <= WR;
                    mem_en    <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_wdata <= mg_merged;
                end
                WR: begin
                    state               <= DONE;
                    mem_en              <= 1'b0;
                    mem_we              <= 1'b0;
                    bus.resp_valid[gnt] <= 1'b1;
`ifdef MEM_ARB_BYTEMASK_EN
                    mem_be              <= 4'h0;
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter and access controller for the CPU's unified word memory. Shares one single-port, synchronous-read memory between two requesters: port 0 is the multicycle CPU datapath; port 1 is a debug/loader master. Converts byte/half/word requests into word-memory cycles, using read-modify-write for sub-word stores. Flags misaligned accesses without touching memory.

## Interface
- ADDR_W, 10, word-address width of the memory (1024 words)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid[p]  in  1  request from port p (p = 0, 1); held stable until accepted
- req_ready[p]  out  1  request accepted this cycle (combinational)
- req_we[p]  in  1  1 = store, 0 = load
- req_size[p]  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned
- req_addr[p]  in  32  byte address
- req_wdata[p]  in  32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
- resp_valid[p]  out  1  one-cycle completion pulse
- resp_err[p]  out  1  misaligned or illegal size; valid with resp_valid
- resp_rdata  out  32  full memory word for loads (0 for stores and errors); valid with resp_valid
- mem_en  out  1  memory cycle enable
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  word address = req_addr[ADDR_W+1:2]; upper bits are ignored (wrap)
- mem_wdata  out  32  write word
- mem_rdata  in  32  read data, valid the cycle after mem_en with mem_we = 0
- mem_be  out  4  byte enables; present only with MEM_ARB_BYTEMASK_EN

## Operation
- **States:** IDLE, RD, MRG, WR, DONE (enum in the package).
- **IDLE:**
  - Grant one valid port and latch its request.
  - Go to DONE if misaligned: half with addr[0] = 1, word with addr[1:0] ≠ 0, or size 11.
  - Otherwise go to RD for a load or a sub-word store (no bytemask).
  - Otherwise go to WR for a word store (or any store with bytemask).
- **Arbitration:** round-robin, 1-bit pointer.
  - When both ports are valid, the pointer port wins.
  - After every grant the pointer moves to the other port.
  - With only one port valid, that port is granted regardless of the pointer.
  - Only one access is outstanding in total; req_ready is 0 outside IDLE.
- **RD:** mem_en = 1, mem_we = 0. Next state is DONE for a load, MRG for a store.
- **MRG:** capture mem_rdata and replace the target lanes, little-endian:
  - SB: wdata[7:0] goes to lane addr[1:0].
  - SH: wdata[15:0] goes to lanes {addr[1],1}:{addr[1],0}.
  - Next state is WR.
- **WR:** mem_en = 1, mem_we = 1, mem_wdata = merged word (word store: wdata). Next state is DONE.
- **DONE:** pulse resp_valid[granted port]; resp_rdata = captured mem_rdata for loads. Next state is IDLE.
- **Non-granted port:** its req_valid is ignored until a later IDLE.
- **Reset values:** all outputs are 0, state = IDLE, pointer = port 0.
- **Reset mid-operation:** mem_en/mem_we drop immediately, no write completes, no response is issued, and the latched request is discarded.

## Timing
- T = accept cycle (req_ready high). All outputs except req_ready are registered.
- Load: RD at T+1, response at T+2.
- Word store: write at T+1, response at T+2.
- Sub-word store (RMW): read at T+1, merge at T+2, write at T+3, response at T+4.
- Misaligned or illegal: response at T+1, resp_err = 1, mem_en never asserted.
- Back-to-back: the next accept can occur in the cycle after DONE, so throughput is one access per 3 cycles at best.

## Configuration
- **MEM_ARB_BYTEMASK_EN defined:**
  - The mem_be port exists and sub-word stores go IDLE→WR→DONE (latency 2).
  - mem_wdata carries the data replicated into the target lanes.
  - mem_be = 0001<<addr[1:0] for SB, 0011<<addr[1:0] for SH, 1111 for SW.
  - MRG is unreachable.
- **Not defined:** no mem_be port; RMW path as above. All word-accurate results are identical either way.

## Structure
- **mem_arb_pkg:** size encodings (SZ_B, SZ_H, SZ_W), state enum, byte-lane mask constants.
- **Sub-module mem_arb_lane_merge** (combinational), one instance:
  - Inputs: old word, wdata, size, addr[1:0].
  - Outputs: merged word, lane mask.
  - Used by MRG, and by WR for mem_be under the macro.

## Test plan
- Port 0 stores 0x112233AA SB@0x100, 0x112233BB SB@0x101, 0x1122DDEE SH@0x102, 0xDEADBEEF SW@0x104 → word 64 = 0xDDEEBBAA and word 65 = 0xDEADBEEF; RMW latency is 4 per sub-word store.
- Both ports assert a load on the same cycle after reset, then both hold valid → port 0 is granted first, port 1 next, then port 0 again (pointer alternation), each response at T+2.
- SH@0x101 and SW@0x102 → resp_err = 1 at T+1, mem_en stays 0, and the target words are unchanged.
- Load at 0x0000_1000 with ADDR_W = 10 → mem_addr = 0 (wrap); resp_rdata = word 0.
- rst asserted during WR of a SW 0xCAFEF00D@0x10 → mem_we low immediately, word 4 unchanged, no resp_valid, state IDLE and pointer = 0 after release.
- With MEM_ARB_BYTEMASK_EN: SB 0x55@0x103 → mem_be = 1000, mem_wdata[31:24] = 0x55, response at T+2.
